// File: rtl/alu_pkg.sv
// alu_pkg: opcode encodings and FSM states shared by the multi-cycle ALU.
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SHL  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_AND  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
    localparam logic [3:0] OP_MULU = 4'd10;
    localparam logic [3:0] OP_DIVU = 4'd11;

    typedef enum logic {IDLE = 1'b0, ITER = 1'b1} state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: request/response handshake bundle of the multi-cycle ALU.
interface alu_mc_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       sel;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] alu_result_hi;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, sel, A, B, out_ready,
        input  in_ready, out_valid, alu_result, alu_result_hi, zero, carry, overflow
    );
    modport slave (
        input  in_valid, sel, A, B, out_ready,
        output in_ready, out_valid, alu_result, alu_result_hi, zero, carry, overflow
    );
endinterface

// File: rtl/alu_md_iter.sv
// alu_md_iter: one-bit-per-cycle unsigned shift-add multiplier / restoring divider.
module alu_md_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic             div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    logic [WIDTH-1:0] hi_q, lo_q, m_q, r;
    logic [WIDTH:0]   sum;
    logic [CNT_W-1:0] cnt;
    logic             div_q, ge;

    // hi/lo are the values after the current step, so the last step's result
    // can be captured by the output registers on the same edge.
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign r    = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign ge   = hi_q[WIDTH-1] || (r >= m_q);
    assign hi   = div_q ? (ge ? r - m_q : r) : sum[WIDTH:1];
    assign lo   = div_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
    assign done = cnt == CNT_W'(WIDTH - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
            cnt   <= '0;
        end else if (start) begin
            hi_q  <= '0;
            lo_q  <= div ? a : b;
            m_q   <= div ? b : a;
            div_q <= div;
            cnt   <= '0;
        end else if (run) begin
            hi_q  <= hi;
            lo_q  <= lo;
            cnt   <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: execute-stage ALU with single-cycle ops, iterative MULU/DIVU,
// registered result/flags and valid/ready handshake on both sides.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input logic      clk,
    input logic      rst,
    alu_mc_if.slave  bus
);
    state_t               state, state_nxt;
    logic                 accept, is_md, md_done, md_fin, c, v, z;
    logic [WIDTH-1:0]     res, md_hi, md_lo;
    logic [WIDTH:0]       add_t, sub_t;
    logic [SHAMT_W-1:0]   shamt;

    assign bus.in_ready = (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign is_md        = (bus.sel == OP_MULU) || (bus.sel == OP_DIVU);
    assign md_done      = (state == ITER) && md_fin;
    assign shamt        = bus.B[SHAMT_W-1:0];
    assign add_t        = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_t        = {1'b0, bus.A} + {1'b0, ~bus.B} + (WIDTH+1)'(1);
    // Reserved opcodes report all flags clear, including zero.
    assign z            = (bus.sel <= OP_SLTU) && (res == '0);

    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.sel)
            OP_ADD: begin
                res = add_t[WIDTH-1:0];
                c   = add_t[WIDTH];
                v   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (add_t[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                res = sub_t[WIDTH-1:0];
                c   = sub_t[WIDTH];
                v   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sub_t[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SHL:  res = bus.A << shamt;
            OP_SHR:  res = bus.A >> shamt;
            OP_SRA:  res = $signed(bus.A) >>> shamt;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            OP_XOR:  res = bus.A ^ bus.B;
            OP_OR:   res = bus.A | bus.B;
            OP_AND:  res = bus.A & bus.B;
            default: ;
        endcase
    end

    alu_md_iter #(.WIDTH(WIDTH)) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (accept && is_md),
        .run   (state == ITER),
        .div   (bus.sel == OP_DIVU),
        .a     (bus.A),
        .b     (bus.B),
        .done  (md_fin),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE) ? ((accept && is_md) ? ITER : IDLE) : (md_fin ? IDLE : ITER);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid     <= 1'b0;
            bus.alu_result    <= '0;
            bus.alu_result_hi <= '0;
            bus.zero          <= 1'b0;
            bus.carry         <= 1'b0;
            bus.overflow      <= 1'b0;
        end else if (accept && !is_md) begin
            bus.out_valid     <= 1'b1;
            bus.alu_result    <= res;
            bus.alu_result_hi <= '0;
            bus.zero          <= z;
            bus.carry         <= c;
            bus.overflow      <= v;
        end else if (md_done) begin
            bus.out_valid     <= 1'b1;
            bus.alu_result    <= md_lo;
            bus.alu_result_hi <= md_hi;
            bus.zero          <= md_lo == '0;
            bus.carry         <= 1'b0;
            bus.overflow      <= 1'b0;
        end else if (bus.out_ready) begin
            bus.out_valid     <= 1'b0;
        end
    end
endmodule
